// File: rtl/regfile_pkg.sv
// Shared constants for the 32-entry register file.
// The build macro REGFILE_BYPASS_EN enables same-edge write-to-read forwarding.
package regfile_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

  // A write takes effect only when it targets a register other than the zero register.
  function automatic logic write_commits(input logic en, input logic [ADDR_W-1:0] addr);
    return en && (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: zero masking plus optional same-edge write forwarding.
// The build macro REGFILE_BYPASS_EN selects forwarding; otherwise the port returns the pre-write value.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] reg_val_i,
  input  logic              wr_commit_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              hit_s;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;

  assign hit_s = BYPASS && wr_commit_i && (wr_addr_i == rd_addr_i);

  // Next read value; the data is held whenever no read is requested.
  always_comb begin
    data_d = data_q;
    if (rd_en_i) begin
      if (rd_addr_i == REG_ZERO) begin
        data_d = '0;
      end else if (hit_s) begin
        data_d = wr_data_i;
      end else begin
        data_d = reg_val_i;
      end
    end else begin
      data_d = data_q;
    end
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign rd_data_o = data_q;

endmodule

// File: rtl/regfile_rw.sv
// 32 x DATA_W register file with two registered read ports, a write port and a commit counter.
// The build macro REGFILE_BYPASS_EN enables same-edge write forwarding in both read ports.
module regfile_rw
  import regfile_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter logic [DATA_W-1:0] SP_RESET = 32'd227
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rd_valid,
  output logic [15:0]       wr_count
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_commit_s;
  logic              rd_valid_d;
  logic              rd_valid_q;
  logic [15:0]       wr_count_d;
  logic [15:0]       wr_count_q;

  assign wr_commit_s = write_commits(wr_en, wr_addr);

  // Register array; entry 0 is never written so it stays zero after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[REG_SP] <= SP_RESET;
    end else if (wr_commit_s) begin
      regs_q[wr_addr] <= wr_data;
    end else begin
      regs_q[wr_addr] <= regs_q[wr_addr];
    end
  end

  // Strobe and commit-counter next state; the counter wraps naturally at 16 bits.
  always_comb begin
    rd_valid_d = rd_en;
    wr_count_d = wr_count_q;
    if (wr_commit_s) begin
      wr_count_d = wr_count_q + 16'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  // Strobe and counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      wr_count_q <= 16'd0;
    end else begin
      rd_valid_q <= rd_valid_d;
      wr_count_q <= wr_count_d;
    end
  end

  regfile_rdport #(.DATA_W(DATA_W)) u_rs_port (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_en_i     (rd_en),
    .rd_addr_i   (rs_addr),
    .reg_val_i   (regs_q[rs_addr]),
    .wr_commit_i (wr_commit_s),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .rd_data_o   (rs_data)
  );

  regfile_rdport #(.DATA_W(DATA_W)) u_rt_port (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_en_i     (rd_en),
    .rd_addr_i   (rt_addr),
    .reg_val_i   (regs_q[rt_addr]),
    .wr_commit_i (wr_commit_s),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .rd_data_o   (rt_data)
  );

  assign rd_valid = rd_valid_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_rw.sv
// Self-checking bench for regfile_rw: directed scenarios plus a randomized run
// against an array-based reference model; honours REGFILE_BYPASS_EN when defined.
module tb_regfile_rw;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [31:0] wr_data = 32'd0;
  logic        rd_en = 1'b0;
  logic [4:0]  rs_addr = 5'd0;
  logic [4:0]  rt_addr = 5'd0;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        rd_valid;
  logic [15:0] wr_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] mem [32];
  logic [31:0] m_rs, m_rt;
  logic        m_valid;
  logic [15:0] m_cnt;

  regfile_rw dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data),
    .rt_data(rt_data), .rd_valid(rd_valid), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic commit);
    if (a == 5'd0) return 32'd0;
    if (BYP && commit && (a == wr_addr)) return wr_data;
    return mem[a];
  endfunction

  // Advance one rising edge and apply the same edge to the model.
  task automatic tick();
    logic commit;
    @(posedge clk);
    #1;
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      mem[29] = 32'd227;
      m_rs = 32'd0; m_rt = 32'd0; m_valid = 1'b0; m_cnt = 16'd0;
    end else begin
      commit = wr_en && (wr_addr != 5'd0);
      if (rd_en) begin
        m_rs = model_read(rs_addr, commit);
        m_rt = model_read(rt_addr, commit);
      end
      m_valid = rd_en;
      if (commit) begin
        mem[wr_addr] = wr_data;
        m_cnt = m_cnt + 16'd1;
      end
    end
  endtask

  task automatic idle();
    reset_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", rd_valid); end
    checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL reset_rs got=%h exp=0", rs_data); end
    checks++; if (rt_data !== 32'd0) begin errors++; $display("FAIL reset_rt got=%h exp=0", rt_data); end
    checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", wr_count); end
    idle(); rd_en = 1'b1; rs_addr = 5'd29; rt_addr = 5'd0;
    tick();
    checks++; if (rs_data !== 32'd227) begin errors++; $display("FAIL reset_sp got=%h exp=%h", rs_data, 32'd227); end
    checks++; if (rt_data !== 32'd0) begin errors++; $display("FAIL reset_r0 got=%h exp=0", rt_data); end
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL reset_rdvalid got=%0b exp=1", rd_valid); end
    checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL reset_count2 got=%0d exp=0", wr_count); end
    idle();
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL strobe_drop got=%0b exp=0", rd_valid); end
    checks++; if (rs_data !== 32'd227) begin errors++; $display("FAIL hold_rs got=%h exp=%h", rs_data, 32'd227); end
  endtask

  task automatic test_zero_reg();
    logic [15:0] c0;
    c0 = wr_count;
    idle(); wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF;
    tick();
    idle(); rd_en = 1'b1; rs_addr = 5'd0; rt_addr = 5'd0;
    tick();
    checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL zero_read got=%h exp=0", rs_data); end
    checks++; if (wr_count !== c0) begin errors++; $display("FAIL zero_count got=%0d exp=%0d", wr_count, c0); end
  endtask

  task automatic test_write_read();
    logic [15:0] c0;
    c0 = wr_count;
    idle(); wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h12345678;
    tick();
    idle(); rd_en = 1'b1; rt_addr = 5'd31; rs_addr = 5'd29;
    tick();
    checks++; if (rt_data !== 32'h12345678) begin errors++; $display("FAIL wr_rd got=%h exp=%h", rt_data, 32'h12345678); end
    checks++; if (wr_count !== c0 + 16'd1) begin errors++; $display("FAIL wr_count got=%0d exp=%0d", wr_count, c0 + 16'd1); end
  endtask

  task automatic test_collision();
    logic [31:0] exp;
    idle(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1;
    tick();
    idle(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h2; rd_en = 1'b1; rs_addr = 5'd5; rt_addr = 5'd6;
    tick();
    exp = BYP ? 32'h2 : 32'h1;
    checks++; if (rs_data !== exp) begin errors++; $display("FAIL collision got=%h exp=%h", rs_data, exp); end
    idle(); rd_en = 1'b1; rs_addr = 5'd5;
    tick();
    checks++; if (rs_data !== 32'h2) begin errors++; $display("FAIL collision_after got=%h exp=%h", rs_data, 32'h2); end
  endtask

  task automatic test_reset_mid();
    reset_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd29; wr_data = 32'hAA; rd_en = 1'b1; rs_addr = 5'd29;
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%0b exp=0", rd_valid); end
    checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", wr_count); end
    idle(); rd_en = 1'b1; rs_addr = 5'd29; rt_addr = 5'd31;
    tick();
    checks++; if (rs_data !== 32'd227) begin errors++; $display("FAIL midrst_sp got=%h exp=%h", rs_data, 32'd227); end
    checks++; if (rt_data !== 32'd0) begin errors++; $display("FAIL midrst_ra got=%h exp=0", rt_data); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      reset_n = ($urandom_range(0, 59) != 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wr_data = $urandom;
      rd_en   = ($urandom_range(0, 2) != 0);
      rs_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      rt_addr = ($urandom_range(0, 1) != 0) ? wr_addr : 5'($urandom);
      tick();
      checks++; if (rs_data !== m_rs) begin errors++; $display("FAIL rand_rs n=%0d got=%h exp=%h", n, rs_data, m_rs); end
      checks++; if (rt_data !== m_rt) begin errors++; $display("FAIL rand_rt n=%0d got=%h exp=%h", n, rt_data, m_rt); end
      checks++; if (rd_valid !== m_valid) begin errors++; $display("FAIL rand_valid n=%0d got=%0b exp=%0b", n, rd_valid, m_valid); end
      checks++; if (wr_count !== m_cnt) begin errors++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, wr_count, m_cnt); end
    end
    idle();
  endtask

  task automatic test_wrap();
    reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    tick();
    idle(); wr_en = 1'b1; wr_addr = 5'd1;
    for (int n = 0; n < 65535; n++) begin
      wr_data = n;
      tick();
    end
    checks++; if (wr_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_max got=%h exp=FFFF", wr_count); end
    wr_data = 32'hCAFE0001;
    tick();
    checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL wrap_zero got=%h exp=0", wr_count); end
    idle(); rd_en = 1'b1; rs_addr = 5'd1;
    tick();
    checks++; if (rs_data !== 32'hCAFE0001) begin errors++; $display("FAIL wrap_data got=%h exp=%h", rs_data, 32'hCAFE0001); end
    idle();
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_write_read();
    test_collision();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
